// File: rtl/demux16_seq.sv
// ============================================================================
// Module   : demux16_seq
// Brief    : Sequential 1-to-16 demultiplexer of 2-bit symbols into registered
//            slots a..p with a FILL/DONE handshake. Optional overrun flag is
//            built when DEMUX16_OVR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux16_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] din,
    input  logic       valid,
    input  logic       ack,
    input  logic       clr,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] c,
    output logic [1:0] d,
    output logic [1:0] e,
    output logic [1:0] f,
    output logic [1:0] g,
    output logic [1:0] h,
    output logic [1:0] i,
    output logic [1:0] j,
    output logic [1:0] k,
    output logic [1:0] l,
    output logic [1:0] m,
    output logic [1:0] n,
    output logic [1:0] o,
    output logic [1:0] p,
    output logic [3:0] idx,
    output logic       done,
    output logic       ovr
);

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_done = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic       w_wr;
    logic [1:0] r_slot [16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_fill;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // clr dominates ack, which dominates valid; idx is always 0 in DONE,
    // so a combined ack+valid lands in slot a and leaves idx at 1.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr        = 1'b0;
        if (clr) begin
            w_state_nxt = c_st_fill;
            w_idx_nxt   = 4'd0;
        end else begin
            case (r_state)
                c_st_fill: begin
                    if (valid) begin
                        w_wr      = 1'b1;
                        w_idx_nxt = r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            w_state_nxt = c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    if (ack) begin
                        w_state_nxt = c_st_fill;
                        if (valid) begin
                            w_wr      = 1'b1;
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_fill;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 16; s++) begin
                r_slot[s] <= 2'b00;
            end
        end else if (w_wr) begin
            r_slot[r_idx] <= din;
        end
    end

`ifdef DEMUX16_OVR_EN
    logic r_ovr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovr <= 1'b0;
        end else if (clr) begin
            r_ovr <= 1'b0;
        end else if ((r_state == c_st_done) && valid && !ack) begin
            r_ovr <= 1'b1;
        end
    end

    assign ovr = r_ovr;
`else
    assign ovr = 1'b0;
`endif

    assign a    = r_slot[0];
    assign b    = r_slot[1];
    assign c    = r_slot[2];
    assign d    = r_slot[3];
    assign e    = r_slot[4];
    assign f    = r_slot[5];
    assign g    = r_slot[6];
    assign h    = r_slot[7];
    assign i    = r_slot[8];
    assign j    = r_slot[9];
    assign k    = r_slot[10];
    assign l    = r_slot[11];
    assign m    = r_slot[12];
    assign n    = r_slot[13];
    assign o    = r_slot[14];
    assign p    = r_slot[15];
    assign idx  = r_idx;
    assign done = (r_state == c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_demux16_seq.sv
// ============================================================================
// Module   : tb_demux16_seq
// Brief    : Self-checking bench for demux16_seq: frame-level reference model
//            compared every cycle, plus hand-computed directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux16_seq;

    logic       clock;
    logic       reset;
    logic [1:0] din;
    logic       valid;
    logic       ack;
    logic       clr;
    logic [1:0] a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p;
    logic [3:0] idx;
    logic       done;
    logic       ovr;

`ifdef DEMUX16_OVR_EN
    localparam bit OVR_EXP = 1'b1;
`else
    localparam bit OVR_EXP = 1'b0;
`endif

    int tests_run;
    int tests_failed;

    demux16_seq u_dut (
        .clock (clock), .reset (reset), .din (din), .valid (valid),
        .ack   (ack),   .clr   (clr),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g), .h (h),
        .i (i), .j (j), .k (k), .l (l), .m (m), .n (n), .o (o), .p (p),
        .idx (idx), .done (done), .ovr (ovr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [31:0] w_all = {p, o, n, m, l, k, j, i, h, g, f, e, d, c, b, a};

    // Frame-level reference: a buffer, a fill count and a "frame full" flag.
    logic [1:0] m_slot [16];
    int         m_cnt;
    bit         m_full;
    bit         m_ovr;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 16; s++) m_slot[s] <= 2'b00;
            m_cnt  <= 0;
            m_full <= 1'b0;
            m_ovr  <= 1'b0;
        end else if (clr) begin
            m_cnt  <= 0;
            m_full <= 1'b0;
            m_ovr  <= 1'b0;
        end else if (m_full) begin
            if (ack) begin
                m_full <= 1'b0;
                if (valid) begin
                    m_slot[0] <= din;
                    m_cnt     <= 1;
                end
            end else if (valid) begin
                m_ovr <= OVR_EXP;
            end
        end else if (valid) begin
            m_slot[m_cnt] <= din;
            m_cnt         <= (m_cnt + 1) % 16;
            m_full        <= (m_cnt == 15);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("model slot[%0d]", s), int'(w_all[2*s +: 2]), int'(m_slot[s]));
        end
        chk("model idx", int'(idx), m_cnt);
        chk("model done", int'(done), int'(m_full));
        chk("model ovr", int'(ovr), int'(m_ovr));
    end

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic drive(input bit v, input bit [1:0] dv, input bit ak, input bit cl);
        valid = v;
        din   = dv;
        ack   = ak;
        clr   = cl;
        @(negedge clock);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        din   = 2'd0;
        valid = 1'b0;
        ack   = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset slots", int'(w_all), 0);
        chk("reset idx", int'(idx), 0);
        chk("reset done", int'(done), 0);
        chk("reset ovr", int'(ovr), 0);
        reset = 1'b0;

        // Full frame of 0,1,2,3 repeating
        for (int s = 0; s < 16; s++) begin
            drive(1'b1, 2'(s % 4), 1'b0, 1'b0);
            if (s == 14) begin
                chk("pre-last idx", int'(idx), 15);
                chk("pre-last done", int'(done), 0);
            end
        end
        chk("frame slots", int'(w_all), 32'hE4E4E4E4);
        chk("frame done", int'(done), 1);
        chk("frame idx", int'(idx), 0);

        // Overrun attempt in DONE
        for (int s = 0; s < 3; s++) drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("ovr slots", int'(w_all), 32'hE4E4E4E4);
        chk("ovr done", int'(done), 1);
        chk("ovr flag", int'(ovr), int'(OVR_EXP));

        // ack with valid in the same cycle
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        chk("ackv done", int'(done), 0);
        chk("ackv slots", int'(w_all), 32'hE4E4E4E7);
        chk("ackv idx", int'(idx), 1);

        // Four more symbols then clr with valid
        for (int s = 0; s < 4; s++) drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("pre-clr idx", int'(idx), 5);
        chk("pre-clr slots", int'(w_all), 32'hE4E4E6AB);
        drive(1'b1, 2'd1, 1'b0, 1'b1);
        chk("clr idx", int'(idx), 0);
        chk("clr done", int'(done), 0);
        chk("clr slots", int'(w_all), 32'hE4E4E6AB);
        chk("clr ovr", int'(ovr), 0);

        // Partial frame then asynchronous reset between edges
        for (int s = 0; s < 9; s++) drive(1'b1, 2'd3, 1'b0, 1'b0);
        chk("pre-rst idx", int'(idx), 9);
        #2 reset = 1'b1;
        #1;
        chk("async rst slots", int'(w_all), 0);
        chk("async rst idx", int'(idx), 0);
        chk("async rst done", int'(done), 0);
        chk("async rst ovr", int'(ovr), 0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("post-rst slots", int'(w_all), 32'h00000002);
        chk("post-rst idx", int'(idx), 1);

        // Gapped stream with ack pulses on idle FILL cycles
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        for (int s = 0; s < 32; s++) begin
            if (s % 2 == 0) drive(1'b1, 2'((s / 2) % 4), 1'b0, 1'b0);
            else            drive(1'b0, 2'd3, (s < 30), 1'b0);
            if (s == 29) begin
                chk("gap pre-last idx", int'(idx), 15);
                chk("gap pre-last done", int'(done), 0);
            end
        end
        chk("gap slots", int'(w_all), 32'hE4E4E4E4);
        chk("gap done", int'(done), 1);
        chk("gap idx", int'(idx), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux16_seq.md
DEMUX16_SEQ -- requirements
Module: demux16_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 2-bit symbol, 16 slots, 4-bit slot index.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  2  incoming symbol.
REQ-005 valid  input  1  din is meaningful this cycle.
REQ-006 ack  input  1  consumer has taken the completed frame.
REQ-007 clr  input  1  synchronous frame abort: restart filling at slot 0.
REQ-008 a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p  output  2 each  registered slots 0..15, in that order.
REQ-009 idx  output  4  index of the next slot to be written.
REQ-010 done  output  1  frame complete; slots a..p stable.
REQ-011 ovr  output  1  sticky overrun flag; see Configuration.

Function
REQ-012 The block SHALL be a sequential 1-to-16 demultiplexer: a stream of 2-bit symbols is distributed into 16 registered slots, slot 0 (a) first.
REQ-013 The FSM SHALL have two states: FILL (done=0) and DONE (done=1).
REQ-014 In FILL, valid=1 SHALL write din into the slot selected by idx at the clock edge; idx increments by 1 in the same edge.
REQ-015 In FILL, valid=1 with idx=15 SHALL write slot p, wrap idx to 0 and enter DONE; done rises in the following cycle (one-cycle latency from the last symbol).
REQ-016 In FILL, valid=0 SHALL leave all slots and idx unchanged.
REQ-017 Non-selected slots SHALL hold their value; only one slot is written per cycle.
REQ-018 In DONE, slots and idx (=0) SHALL be frozen and valid without ack SHALL be ignored for data purposes.
REQ-019 In DONE, ack=1 SHALL return to FILL on the next edge.
REQ-020 In DONE, ack=1 and valid=1 in the same cycle SHALL return to FILL, write din into slot a and set idx to 1; no symbol is lost.
REQ-021 ack in FILL SHALL have no effect.
REQ-022 clr=1 SHALL, on the next edge and in any state, set idx to 0 and the state to FILL; slot contents are retained.
REQ-023 Priority SHALL be clr > ack > valid; valid together with clr is discarded.
REQ-024 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-025 reset=1 SHALL immediately, independent of clock, force: all slots a..p = 2'b00, idx = 0, state FILL, done = 0, ovr = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the first valid symbol goes to slot a.
REQ-027 Deassertion of reset SHALL take effect at the next rising clock edge; no input is sampled while reset=1.

Configuration
REQ-028 Macro DEMUX16_OVR_EN SHALL control overrun detection.
REQ-029 With DEMUX16_OVR_EN defined: valid=1 while in DONE with ack=0 and clr=0 SHALL set ovr on the next edge; ovr stays set until clr or reset.
REQ-030 Without DEMUX16_OVR_EN: the ovr port SHALL remain present and be held at constant 0; no overrun logic is synthesised.

Verification
REQ-031 Reset, then 16 valid symbols cycling 0,1,2,3,0,1,... -> a=0,b=1,c=2,d=3,...,p=3; done=1 one cycle after 16th symbol; idx=0.
REQ-032 In DONE, drive valid=1 din=2 for 3 cycles with ack=0 -> slots unchanged, done stays 1; ovr=1 if DEMUX16_OVR_EN defined, else ovr=0.
REQ-033 In DONE, ack=1 and valid=1 din=3 together -> next cycle done=0, a=3, idx=1, b..p unchanged.
REQ-034 After 5 symbols (idx=5) assert clr with valid=1 din=1 -> idx=0, state FILL, slots a..e keep prior values, f unchanged; ovr cleared.
REQ-035 Assert reset asynchronously between clock edges at idx=9 -> all slots 0, idx=0, done=0, ovr=0 immediately; next valid din=2 lands in a.
REQ-036 Gapped input: valid toggling 1,0,1,0 over 32 cycles -> exactly 16 writes, done after the 16th, idx never skips.
